// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_defs;

    localparam int DEFAULT_WIDTH = 8;

    // 2'd3 is unused; the FSM treats it as illegal and returns to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; master drives operands, slave returns the result.
//
// Handshake: an operation is accepted on a rising edge where start = 1 and ready = 1;
// a, b and bin are sampled on that edge only. done is high for exactly one cycle, and
// diff/bout are valid then and hold until the next accepted start.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_defs::DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  ready, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output ready, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor_fullsubtractor.sv
// One-bit full subtractor: D = A - B - Bin, with Bout set when A < B + Bin.
module fullsubtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);
    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: computes a - b - bin one bit per clock through a
// single full-subtractor stage with a registered borrow.
module serial_subtractor
    import serial_defs::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_subtractor_if.slave    bus,
    output state_t                dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sa, sa_nxt;
    logic [WIDTH-1:0] sb, sb_nxt;
    logic [WIDTH-1:0] sd, sd_nxt;
    logic             br, br_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             bit_d, bit_bo;

    fullsubtractor u_fs (
        .A    (sa[0]),
        .B    (sb[0]),
        .Bin  (br),
        .D    (bit_d),
        .Bout (bit_bo)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            sa    <= '0;
            sb    <= '0;
            sd    <= '0;
            br    <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            sa    <= sa_nxt;
            sb    <= sb_nxt;
            sd    <= sd_nxt;
            br    <= br_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sa_nxt    = sa;
        sb_nxt    = sb;
        sd_nxt    = sd;
        br_nxt    = br;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    sa_nxt    = bus.a;
                    sb_nxt    = bus.b;
                    br_nxt    = bus.bin;
                    sd_nxt    = '0;
                    cnt_nxt   = '0;
                    state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Result enters at the MSB so that after WIDTH shifts bit 0 sits at sd[0].
                sd_nxt            = sd >> 1;
                sd_nxt[WIDTH-1]   = bit_d;
                sa_nxt            = sa >> 1;
                sb_nxt            = sb >> 1;
                br_nxt            = bit_bo;
                cnt_nxt           = cnt + 1'b1;
                if (cnt == LAST_BIT) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded only from registers, never from the inputs.
    assign bus.ready = (state == ST_IDLE);
    assign bus.done  = (state == ST_DONE);
    assign bus.diff  = sd;
    assign bus.bout  = br;
    assign dbg_state = state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: drivers push expected {bout, diff} and done cycle,
// a negedge monitor pops and compares on every done pulse.
module tb_serial_subtractor;
    import serial_defs::*;

    localparam int W = 8;

    logic clk;
    logic reset;
    int   cycle;
    int   checks;
    int   errors;
    state_t dbg_state;

    logic [W:0] exp_q[$];
    int         exp_t_q[$];

    serial_subtractor_if #(.WIDTH(W)) bus ();

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [W:0] ref_sub(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic bin);
        int r;
        r = int'(a) - int'(b) - int'(bin);
        ref_sub[W-1:0] = W'(r);
        ref_sub[W]     = (r < 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W:0] e;
        int         et;
        if (!reset && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cycle);
            end else begin
                e  = exp_q.pop_front();
                et = exp_t_q.pop_front();
                chk("result", 32'({bus.bout, bus.diff}), 32'(e));
                chk("done_cycle", 32'(cycle), 32'(et));
            end
        end
    end

    // drivers
    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=%b expected 1 within 100 cycles", bus.ready);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                         input bit track);
        wait_ready();
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        if (track) begin
            exp_q.push_back(ref_sub(a, b, bin));
            exp_t_q.push_back(cycle + 1 + W);
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = W'($urandom);
        bus.b     = W'($urandom);
        bus.bin   = 1'($urandom);
        chk("ready_low_after_accept", 32'(bus.ready), 32'd0);
    endtask

    task automatic check_idle_reset_values(input string tag);
        chk({tag, "_ready"}, 32'(bus.ready), 32'd1);
        chk({tag, "_done"},  32'(bus.done),  32'd0);
        chk({tag, "_diff"},  32'(bus.diff),  32'd0);
        chk({tag, "_bout"},  32'(bus.bout),  32'd0);
        chk({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_reset_values("reset");
        reset = 1'b0;

        // directed cases
        issue(8'd100, 8'd37, 1'b0, 1'b1);
        issue(8'd5,   8'd9,  1'b0, 1'b1);
        issue(8'd0,   8'd0,  1'b1, 1'b1);
        issue(8'hFF,  8'hFF, 1'b0, 1'b1);
        // start with new operands while busy must be ignored
        bus.start = 1'b1;
        repeat (3) begin
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.bin = 1'($urandom);
            @(negedge clk);
            chk("busy_ready_low", 32'(bus.ready), 32'd0);
        end
        bus.start = 1'b0;
        issue(8'h00, 8'hFF, 1'b1, 1'b1);
        issue(8'h80, 8'h7F, 1'b1, 1'b1);

        // reset mid-operation at edge k+4: no done for the aborted op
        issue(8'd200, 8'd13, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_reset_values("midreset");
        repeat (W + 4) @(negedge clk);
        chk("midreset_still_idle", 32'(bus.ready), 32'd1);

        // reset and start on the same edge: reset wins
        bus.start = 1'b1;
        reset     = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        reset     = 1'b0;
        chk("reset_start_ready", 32'(bus.ready), 32'd1);

        // random operations with random gaps
        for (int i = 0; i < 40; i++) begin
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
            repeat ($urandom_range(0, W + 3)) @(negedge clk);
        end

        // back-to-back with start held high: accepted every W+2 edges
        wait_ready();
        bus.start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.a   = W'($urandom);
            bus.b   = W'($urandom);
            bus.bin = 1'($urandom);
            chk("b2b_ready", 32'(bus.ready), 32'd1);
            exp_q.push_back(ref_sub(bus.a, bus.b, bus.bin));
            exp_t_q.push_back(cycle + 1 + W);
            repeat (W + 2) begin
                @(negedge clk);
                bus.a   = W'($urandom);
                bus.b   = W'($urandom);
                bus.bin = 1'($urandom);
            end
        end
        bus.start = 1'b0;

        // drain
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (W + 4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
